// File: rtl/multicycle_adder.sv
// Multi-cycle ripple adder: WIDTH-bit A + B + Cin, CHUNK bits per clock, valid/ready in and out.
// Define MULTICYCLE_ADDER_OVERFLOW_EN to add the registered signed-overflow output o_Overflow.
module multicycle_adder #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic             i_Clk,
  input  logic             i_Rst_n,
  input  logic             i_Valid,
  output logic             o_Ready,
  input  logic [WIDTH-1:0] i_A,
  input  logic [WIDTH-1:0] i_B,
  input  logic             i_Cin,
  output logic             o_Valid,
  input  logic             i_Ready,
  output logic [WIDTH-1:0] o_Sum,
  output logic             o_Cout
`ifdef MULTICYCLE_ADDER_OVERFLOW_EN
  ,
  output logic             o_Overflow
`endif
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NCHUNK - 1);

  typedef enum logic [1:0] {
    IDLE,
    ADD,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0]       a_sh, b_sh;
  logic [WIDTH-1:0]       acc_q, acc_d;
  logic                   carry_q;
  logic [CNT_W-1:0]       k_q;
  logic [CHUNK:0]         chunk_sum;
  logic [WIDTH+CHUNK-1:0] acc_ext;
  logic                   accept;
  logic                   last;

  assign accept = i_Valid && o_Ready;
  assign last   = (k_q == LAST);

  // The low chunk of each shifted operand is always the one being added this cycle.
  assign chunk_sum = {1'b0, a_sh[CHUNK-1:0]} + {1'b0, b_sh[CHUNK-1:0]}
                   + {{CHUNK{1'b0}}, carry_q};
  assign acc_ext   = {chunk_sum[CHUNK-1:0], acc_q};
  assign acc_d     = acc_ext[WIDTH+CHUNK-1:CHUNK];

  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch is inferred.
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = ADD;
      ADD:     if (last) state_d = DONE;
      DONE:    if (i_Ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs are registered from the next state, so no input reaches them combinationally.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      // NOTE: non-blocking assignments for all sequential state, so every flop samples pre-edge values.
      state_q <= IDLE;
      o_Ready <= 1'b0;
      o_Valid <= 1'b0;
    end else begin
      state_q <= state_d;
      o_Ready <= (state_d == IDLE);
      o_Valid <= (state_d == DONE);
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      a_sh    <= '0;
      b_sh    <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      k_q     <= '0;
      o_Sum   <= '0;
      o_Cout  <= 1'b0;
`ifdef MULTICYCLE_ADDER_OVERFLOW_EN
      o_Overflow <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            a_sh    <= i_A;
            b_sh    <= i_B;
            carry_q <= i_Cin;
            k_q     <= '0;
          end
        end
        ADD: begin
          a_sh    <= a_sh >> CHUNK;
          b_sh    <= b_sh >> CHUNK;
          carry_q <= chunk_sum[CHUNK];
          acc_q   <= acc_d;
          k_q     <= k_q + CNT_W'(1);
          if (last) begin
            o_Sum  <= acc_d;
            o_Cout <= chunk_sum[CHUNK];
`ifdef MULTICYCLE_ADDER_OVERFLOW_EN
            // Carry into the MSB is recovered as a ^ b ^ sum at that bit.
            o_Overflow <= (a_sh[CHUNK-1] ^ b_sh[CHUNK-1] ^ chunk_sum[CHUNK-1])
                        ^ chunk_sum[CHUNK];
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_adder.sv
// Scoreboard bench for multicycle_adder: an 8/2 instance under directed and random traffic,
// plus an 8/8 instance for single-cycle back-to-back timing.
module tb_multicycle_adder;

  localparam int W = 8;
  localparam int C = 2;
  localparam int N = W / C;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    int           acc_cyc;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Instance under scoreboard (WIDTH=8, CHUNK=2)
  logic         a_iv, a_ready, a_cin, a_ov, a_ir, a_cout;
  logic [W-1:0] a_a, a_b, a_sum;
  // Single-chunk instance (WIDTH=CHUNK=8)
  logic         d_iv, d_ready, d_cin, d_ov, d_ir, d_cout;
  logic [W-1:0] d_a, d_b, d_sum;
`ifdef MULTICYCLE_ADDER_OVERFLOW_EN
  logic a_ovf, d_ovf;
`endif

  multicycle_adder #(.WIDTH(W), .CHUNK(C)) dut (
    .i_Clk(clk), .i_Rst_n(rst_n), .i_Valid(a_iv), .o_Ready(a_ready),
    .i_A(a_a), .i_B(a_b), .i_Cin(a_cin), .o_Valid(a_ov), .i_Ready(a_ir),
    .o_Sum(a_sum), .o_Cout(a_cout)
`ifdef MULTICYCLE_ADDER_OVERFLOW_EN
    , .o_Overflow(a_ovf)
`endif
  );

  multicycle_adder #(.WIDTH(W), .CHUNK(W)) dut_one (
    .i_Clk(clk), .i_Rst_n(rst_n), .i_Valid(d_iv), .o_Ready(d_ready),
    .i_A(d_a), .i_B(d_b), .i_Cin(d_cin), .o_Valid(d_ov), .i_Ready(d_ir),
    .o_Sum(d_sum), .o_Cout(d_cout)
`ifdef MULTICYCLE_ADDER_OVERFLOW_EN
    , .o_Overflow(d_ovf)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: wait bound expired, got no event, expected one (t=%0t)", name, $time);
  endtask

  // Reference: exact integer arithmetic, unsigned for sum/carry and signed range test for overflow.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic cin, input int c);
    exp_t       e;
    logic [W:0] full;
    int         s;
    full      = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    s         = int'($signed(a)) + int'($signed(b)) + int'(cin);
    e.sum     = full[W-1:0];
    e.cout    = full[W];
    e.ovf     = (s > (2 ** (W - 1)) - 1) || (s < -(2 ** (W - 1)));
    e.acc_cyc = c;
    return e;
  endfunction

  // Scoreboard: accepts push the model result; the monitor compares whenever o_Valid is up.
  exp_t q[$];
  logic prev_ov = 1'b0;
  logic hs_prev = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      prev_ov = 1'b0;
      hs_prev = 1'b0;
    end else begin
      if (hs_prev) begin
        check("ready_after_handshake", a_ready, 1);
        check("valid_after_handshake", a_ov, 0);
      end
      if (a_ov) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_valid: got o_Valid=1, expected 0 with no operation pending (t=%0t)",
                   $time);
        end else begin
          if (!prev_ov) check("latency", cyc - q[0].acc_cyc, N + 1);
          check("sum", a_sum, q[0].sum);
          check("cout", a_cout, q[0].cout);
`ifdef MULTICYCLE_ADDER_OVERFLOW_EN
          check("overflow", a_ovf, q[0].ovf);
`endif
          check("ready_in_done", a_ready, 0);
        end
      end else if (q.size() > 0) begin
        check("ready_while_busy", a_ready, 0);
      end
      hs_prev = a_ov && a_ir;
      if (a_ov && a_ir && q.size() > 0) void'(q.pop_front());
      if (a_iv && a_ready) q.push_back(model(a_a, a_b, a_cin, cyc));
      prev_ov = a_ov;
    end
  end

  logic sink_rand = 1'b0;
  always @(posedge clk) begin
    #1;
    if (sink_rand) a_ir = ($urandom_range(0, 3) != 0);
  end

  // Call at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    bit done;
    done = 1'b0;
    a_a  = a;
    a_b  = b;
    a_cin = cin;
    a_iv = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (a_ready) done = 1'b1;
    end
    if (!done) timeout("accept_wait");
    @(posedge clk);
    #1;
    a_iv = 1'b0;
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 500 && !done; i++) begin
      @(negedge clk);
      if (q.size() == 0 && a_ready && !a_ov) done = 1'b1;
    end
    if (!done) timeout("idle_wait");
    @(posedge clk);
    #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, expected completion earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e1, e2;
    int   c0;
    bit   done;

    a_iv = 1'b0; a_a = '0; a_b = '0; a_cin = 1'b0; a_ir = 1'b1;
    d_iv = 1'b0; d_a = '0; d_b = '0; d_cin = 1'b0; d_ir = 1'b1;

    // Reset held across edges
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", a_ready, 0);
    check("rst_valid", a_ov, 0);
    check("rst_sum", a_sum, 0);
    check("rst_cout", a_cout, 0);
    check("rst_one_ready", d_ready, 0);
    check("rst_one_valid", d_ov, 0);
`ifdef MULTICYCLE_ADDER_OVERFLOW_EN
    check("rst_overflow", a_ovf, 0);
`endif
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    check("ready_before_first_edge", a_ready, 0);
    @(posedge clk);
    #1;
    check("ready_after_release", a_ready, 1);
    check("one_ready_after_release", d_ready, 1);

    // Directed operations with the sink always ready
    do_op(8'h5A, 8'h33, 1'b0);
    do_op(8'hFF, 8'h01, 1'b1);
    do_op(8'h80, 8'h80, 1'b0);
    wait_idle();

    // Backpressure: result held for 10 cycles while new operands are offered
    a_ir = 1'b0;
    do_op(8'hC3, 8'h5A, 1'b1);
    done = 1'b0;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (a_ov) done = 1'b1;
    end
    if (!done) timeout("bp_valid_wait");
    @(posedge clk);
    #1;
    a_iv = 1'b1; a_a = 8'h11; a_b = 8'h22; a_cin = 1'b0;
    repeat (10) begin
      @(negedge clk);
      check("bp_valid_held", a_ov, 1);
      check("bp_ready_low", a_ready, 0);
    end
    @(posedge clk);
    #1;
    a_iv = 1'b0;
    a_ir = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release_ready", a_ready, 1);
    check("bp_release_valid", a_ov, 0);

    // Reset during the second ADD cycle aborts the operation
    do_op(8'h12, 8'h34, 1'b0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_valid", a_ov, 0);
    check("abort_ready", a_ready, 0);
    check("abort_sum", a_sum, 0);
    check("abort_cout", a_cout, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    repeat (N + 4) @(posedge clk);
    #1;
    check("abort_no_valid", a_ov, 0);
    do_op(8'h01, 8'h01, 1'b0);
    wait_idle();

    // Random traffic with a randomly stalling sink
    sink_rand = 1'b1;
    repeat (40) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      do_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
    end
    done = 1'b0;
    for (int i = 0; i < 1000 && !done; i++) begin
      @(negedge clk);
      if (q.size() == 0 && !a_ov) done = 1'b1;
    end
    if (!done) timeout("drain_wait");
    sink_rand = 1'b0;
    a_ir = 1'b1;

    // Single-chunk instance: back-to-back with the sink always ready
    @(posedge clk);
    #1;
    e1 = model(8'h7F, 8'h01, 1'b0, 0);
    e2 = model(8'hF0, 8'h0F, 1'b1, 0);
    d_a = 8'h7F; d_b = 8'h01; d_cin = 1'b0; d_iv = 1'b1; d_ir = 1'b1;
    done = 1'b0;
    c0 = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (d_ready) begin
        done = 1'b1;
        c0 = cyc;
      end
    end
    if (!done) timeout("one_accept_wait");
    @(posedge clk);
    #1;
    d_a = 8'hF0; d_b = 8'h0F; d_cin = 1'b1;
    @(negedge clk);
    check("one_add_valid", d_ov, 0);
    check("one_add_ready", d_ready, 0);
    @(negedge clk);
    check("one_valid_1", d_ov, 1);
    check("one_sum_1", d_sum, e1.sum);
    check("one_cout_1", d_cout, e1.cout);
`ifdef MULTICYCLE_ADDER_OVERFLOW_EN
    check("one_overflow_1", d_ovf, e1.ovf);
`endif
    @(negedge clk);
    check("one_idle_valid", d_ov, 0);
    check("one_idle_ready", d_ready, 1);
    check("one_accept_spacing", cyc - c0, 3);
    @(posedge clk);
    #1;
    d_iv = 1'b0;
    @(negedge clk);
    check("one_add_valid_2", d_ov, 0);
    @(negedge clk);
    check("one_valid_2", d_ov, 1);
    check("one_sum_2", d_sum, e2.sum);
    check("one_cout_2", d_cout, e2.cout);
`ifdef MULTICYCLE_ADDER_OVERFLOW_EN
    check("one_overflow_2", d_ovf, e2.ovf);
`endif
    @(negedge clk);
    check("one_final_valid", d_ov, 0);
    check("one_final_ready", d_ready, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
